// File: rtl/addsub_signed_pipe.sv
// Pipelined signed add/subtract with exact overflow detection, elastic valid/ready stages and
// overflow statistics. Define SATURATE_EN to clamp overflowed results instead of wrapping.
module addsub_signed_pipe #(
   parameter int WIDTH     = 16,
   parameter int STAGES    = 2,
   parameter int OVF_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_result,
   output logic                 out_overflow,
   input  logic                 clr_stats,
   output logic                 ovf_sticky,
   output logic [OVF_CNT_W-1:0] ovf_count
);

   logic [WIDTH:0]   a_ext;
   logic [WIDTH:0]   b_ext;
   logic [WIDTH:0]   ext;
   logic [WIDTH-1:0] d_res;
   logic             d_ovf;

   always_comb begin
      a_ext = {in_a[WIDTH-1], in_a};
      b_ext = {in_b[WIDTH-1], in_b};
      ext   = in_op ? a_ext + b_ext : a_ext - b_ext;
      d_ovf = ext[WIDTH] ^ ext[WIDTH-1];
      d_res = ext[WIDTH-1:0];
`ifdef SATURATE_EN
      // ext[WIDTH] is the true sign: positive overflow -> max, negative -> min
      if (d_ovf) begin
         d_res           = ext[WIDTH] ? '0 : '1;
         d_res[WIDTH-1]  = ext[WIDTH];
      end
`endif
   end

   logic [STAGES-1:0] vld_vec;
   logic [STAGES-1:0] ovf_vec;
   logic [STAGES-1:0] rdy;
   logic [WIDTH-1:0]  res_arr [STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             src_vld;
      logic [WIDTH-1:0] src_res;
      logic             src_ovf;
      logic             vld_q;
      logic [WIDTH-1:0] res_q;
      logic             ovf_q;

      if (k == 0) begin : g_head
         assign src_vld = in_valid;
         assign src_res = d_res;
         assign src_ovf = d_ovf;
      end else begin : g_body
         assign src_vld = vld_vec[k-1];
         assign src_res = res_arr[k-1];
         assign src_ovf = ovf_vec[k-1];
      end

      // Unrolled ready ripple: stage k can load if any stage from k onward has a hole,
      // or the output is draining.
      assign rdy[k] = out_ready || !(&vld_vec[STAGES-1:k]);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            res_q <= '0;
            ovf_q <= 1'b0;
         end else if (rdy[k]) begin
            vld_q <= src_vld;
            if (src_vld) begin
               res_q <= src_res;
               ovf_q <= src_ovf;
            end
         end
      end

      assign vld_vec[k] = vld_q;
      assign ovf_vec[k] = ovf_q;
      assign res_arr[k] = res_q;
   end

   assign in_ready     = rdy[0];
   assign out_valid    = vld_vec[STAGES-1];
   assign out_result   = res_arr[STAGES-1];
   assign out_overflow = ovf_vec[STAGES-1];

   logic ovf_event;
   assign ovf_event = out_valid && out_ready && out_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else if (clr_stats) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else if (ovf_event) begin
         ovf_sticky <= 1'b1;
         if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_addsub_signed_pipe.sv
// Self-checking bench for addsub_signed_pipe: three instances (STAGES 2/1/4), table vectors,
// operand sweep, backpressure, stats saturation/clear, async reset and random streams.
module tb_addsub_signed_pipe;

`ifdef SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        iv   [3];
   logic        ir   [3];
   logic [15:0] ia   [3];
   logic [15:0] ib   [3];
   logic        iop  [3];
   logic        ov   [3];
   logic        orr  [3];
   logic [15:0] ores [3];
   logic        oovf [3];
   logic        clr  [3];
   logic        st   [3];
   logic [7:0]  cnt  [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      localparam int C = (g == 0) ? 8 : 2;
      logic [C-1:0] c;
      addsub_signed_pipe #(.WIDTH(16), .STAGES(S), .OVF_CNT_W(C)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .in_valid(iv[g]), .in_ready(ir[g]), .in_a(ia[g]), .in_b(ib[g]), .in_op(iop[g]),
         .out_valid(ov[g]), .out_ready(orr[g]), .out_result(ores[g]), .out_overflow(oovf[g]),
         .clr_stats(clr[g]), .ovf_sticky(st[g]), .ovf_count(c)
      );
      assign cnt[g] = 8'(c);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed { logic ovf; logic [15:0] res; } rr_t;
   typedef struct { int inst; logic [15:0] res; logic ovf; int acc; bit exact; } sb_t;
   typedef struct { logic [15:0] a; logic [15:0] b; logic op; logic [15:0] res; logic ovf; } vec_t;

   sb_t sb [$];
   int  n_chk = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  acc_cnt [3] = '{0, 0, 0};
   int  out_cnt [3] = '{0, 0, 0};
   bit  lat_exact = 1'b0;
   int  edge_vals [9] = '{0, 1, -1, 32767, -32768, 32766, -32767, 16384, -16384};

   function automatic int stages_of(int i);
      return (i == 0) ? 2 : (i == 1) ? 1 : 4;
   endfunction

   // Reference: exact integer arithmetic, then range check against the 16-bit signed range.
   function automatic rr_t model(logic [15:0] a, logic [15:0] b, logic op);
      int   x;
      int   y;
      int   s;
      rr_t  r;
      x = int'($signed(a));
      y = int'($signed(b));
      s = op ? x + y : x - y;
      r.ovf = (s > 32767) || (s < -32768);
      r.res = 16'(s);
      if (SAT && s > 32767)  r.res = 16'h7fff;
      if (SAT && s < -32768) r.res = 16'h8000;
      return r;
   endfunction

   function automatic int pending(int i);
      int n = 0;
      foreach (sb[k]) if (sb[k].inst == i) n++;
      return n;
   endfunction

   function automatic logic [15:0] pick();
      if ($urandom_range(0, 3) == 0) return 16'(edge_vals[$urandom_range(0, 8)]);
      return 16'($urandom);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // One clock: scoreboard both interfaces at the falling edge, then step past the rising edge.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (rst_n && ov[i] && orr[i]) begin
            int idx;
            idx = -1;
            for (int k = 0; k < sb.size(); k++) if (idx < 0 && sb[k].inst == i) idx = k;
            chk($sformatf("beat_pending[%0d]", i), idx >= 0, 1);
            if (idx >= 0) begin
               chk($sformatf("result[%0d]", i), ores[i], sb[idx].res);
               chk($sformatf("overflow[%0d]", i), oovf[i], sb[idx].ovf);
               if (sb[idx].exact)
                  chk($sformatf("latency[%0d]", i), cyc - sb[idx].acc, stages_of(i));
               else
                  chk($sformatf("latency_min[%0d]", i), (cyc - sb[idx].acc) >= stages_of(i), 1);
               sb.delete(idx);
            end
            out_cnt[i]++;
         end
         if (rst_n && iv[i] && ir[i]) begin
            rr_t r;
            r = model(ia[i], ib[i], iop[i]);
            sb.push_back('{i, r.res, r.ovf, cyc, lat_exact});
            acc_cnt[i]++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(int i);
      iv[i]  = 1'b0;
      orr[i] = 1'b1;
      for (int t = 0; t < 50 && pending(i) > 0; t++) tick();
      chk($sformatf("drain[%0d]", i), pending(i), 0);
   endtask

   task automatic send_one(int i, logic [15:0] a, logic [15:0] b, logic op);
      int base;
      base   = acc_cnt[i];
      iv[i]  = 1'b1;
      ia[i]  = a;
      ib[i]  = b;
      iop[i] = op;
      orr[i] = 1'b1;
      for (int t = 0; t < 20 && acc_cnt[i] == base; t++) tick();
      chk($sformatf("send_accepted[%0d]", i), acc_cnt[i] - base, 1);
      drain(i);
   endtask

   task automatic stream(int i, int n, bit rnd);
      int base;
      base      = acc_cnt[i];
      lat_exact = !rnd;
      for (int t = 0; t < n * 20 && acc_cnt[i] - base < n; t++) begin
         iv[i]  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         ia[i]  = pick();
         ib[i]  = pick();
         iop[i] = 1'($urandom);
         orr[i] = rnd ? 1'($urandom) : 1'b1;
         tick();
      end
      iv[i] = 1'b0;
      chk($sformatf("stream_accepted[%0d]", i), acc_cnt[i] - base, n);
      drain(i);
      lat_exact = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t tv [10];
      logic [15:0] held_r;
      logic        held_o;
      int          base;
      int          obase;

      tv[0] = '{16'h0000, 16'h8000, 1'b0, SAT ? 16'h7fff : 16'h8000, 1'b1};
      tv[1] = '{16'h8000, 16'hffff, 1'b1, SAT ? 16'h8000 : 16'h7fff, 1'b1};
      tv[2] = '{16'h7fff, 16'h0001, 1'b1, SAT ? 16'h7fff : 16'h8000, 1'b1};
      tv[3] = '{16'h0064, 16'h00fa, 1'b0, 16'hff6a, 1'b0};
      tv[4] = '{16'hffff, 16'hffff, 1'b0, 16'h0000, 1'b0};
      tv[5] = '{16'h8000, 16'h0001, 1'b0, SAT ? 16'h8000 : 16'h7fff, 1'b1};
      tv[6] = '{16'h4000, 16'h3fff, 1'b1, 16'h7fff, 1'b0};
      tv[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0};
      tv[8] = '{16'h7fff, 16'h8000, 1'b0, SAT ? 16'h7fff : 16'hffff, 1'b1};
      tv[9] = '{16'hc000, 16'hc000, 1'b1, 16'h8000, 1'b0};

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; ia[i] = '0; ib[i] = '0; iop[i] = 1'b0; orr[i] = 1'b1; clr[i] = 1'b0;
      end

      // Reset state
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_out_valid[%0d]", i), ov[i], 0);
         chk($sformatf("rst_out_result[%0d]", i), ores[i], 0);
         chk($sformatf("rst_out_overflow[%0d]", i), oovf[i], 0);
         chk($sformatf("rst_sticky[%0d]", i), st[i], 0);
         chk($sformatf("rst_count[%0d]", i), cnt[i], 0);
      end
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("rst_in_ready[%0d]", i), ir[i], 1);

      // Directed vectors, one beat at a time
      foreach (tv[v]) begin
         iv[0] = 1'b1; ia[0] = tv[v].a; ib[0] = tv[v].b; iop[0] = tv[v].op;
         tick();
         iv[0] = 1'b0;
         for (int t = 0; t < 10 && !ov[0]; t++) tick();
         chk($sformatf("vec%0d_valid", v), ov[0], 1);
         chk($sformatf("vec%0d_result", v), ores[0], tv[v].res);
         chk($sformatf("vec%0d_overflow", v), oovf[0], tv[v].ovf);
         tick();
      end
      drain(0);

      // Edge-value sweep, back-to-back with out_ready high: exact latency
      base      = acc_cnt[0];
      lat_exact = 1'b1;
      for (int t = 0; t < 400 && acc_cnt[0] - base < 162; t++) begin
         int k;
         k      = acc_cnt[0] - base;
         iv[0]  = 1'b1;
         ia[0]  = 16'(edge_vals[k / 18]);
         ib[0]  = 16'(edge_vals[(k / 2) % 9]);
         iop[0] = 1'(k % 2);
         tick();
      end
      iv[0] = 1'b0;
      chk("sweep_accepted", acc_cnt[0] - base, 162);
      drain(0);
      lat_exact = 1'b0;

      // Backpressure: 10 beats, out_ready low for cycles 3..7
      base  = acc_cnt[0];
      obase = out_cnt[0];
      held_r = '0;
      held_o = 1'b0;
      for (int t = 0; t < 60; t++) begin
         iv[0]  = (acc_cnt[0] - base) < 10;
         ia[0]  = pick();
         ib[0]  = pick();
         iop[0] = 1'($urandom);
         orr[0] = !(t >= 3 && t <= 7);
         if (t == 3) begin
            held_r = ores[0];
            held_o = oovf[0];
         end
         tick();
         if (t >= 3 && t <= 7) begin
            chk("stall_valid", ov[0], 1);
            chk("stall_result", ores[0], held_r);
            chk("stall_overflow", oovf[0], held_o);
            chk("stall_in_ready", ir[0], 0);
         end
         if (acc_cnt[0] - base >= 10 && pending(0) == 0) break;
      end
      iv[0] = 1'b0;
      chk("bp_beats_in", acc_cnt[0] - base, 10);
      chk("bp_beats_out", out_cnt[0] - obase, 10);
      chk("bp_pending", pending(0), 0);

      // Stats saturation on the 2-bit counter instance, then clear colliding with an event
      for (int k = 1; k <= 5; k++) begin
         send_one(1, 16'h7fff, 16'h0001, 1'b1);
         chk($sformatf("ovf_count_%0d", k), cnt[1], (k > 3) ? 3 : k);
         chk($sformatf("ovf_sticky_%0d", k), st[1], 1);
      end
      base  = acc_cnt[1];
      iv[1] = 1'b1; ia[1] = 16'h0000; ib[1] = 16'h8000; iop[1] = 1'b0;
      tick();
      iv[1] = 1'b0;
      chk("clr_beat_accepted", acc_cnt[1] - base, 1);
      chk("clr_beat_valid", ov[1], 1);
      clr[1] = 1'b1;
      tick();
      clr[1] = 1'b0;
      chk("clr_count", cnt[1], 0);
      chk("clr_sticky", st[1], 0);
      chk("clr_pending", pending(1), 0);

      // Random traffic on STAGES=1 and STAGES=4
      stream(1, 20, 1'b0);
      stream(1, 200, 1'b1);
      stream(2, 20, 1'b0);
      stream(2, 200, 1'b1);

      // Async reset with two beats in flight
      orr[0] = 1'b1;
      iv[0] = 1'b1; ia[0] = 16'h1234; ib[0] = 16'h0001; iop[0] = 1'b1;
      tick();
      ia[0] = 16'h7fff; ib[0] = 16'hffff; iop[0] = 1'b0;
      tick();
      iv[0] = 1'b0;
      chk("pre_reset_valid", ov[0], 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", ov[0], 0);
      chk("async_rst_result", ores[0], 0);
      chk("async_rst_count", cnt[0], 0);
      for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].inst == 0) sb.delete(k);
      tick();
      rst_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick();
         chk("post_rst_no_stale", ov[0], 0);
      end
      chk("post_rst_count", cnt[0], 0);
      chk("post_rst_sticky", st[0], 0);
      chk("post_rst_in_ready", ir[0], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
